// File: rtl/seven_segment_pkg.sv
// Shared types and the hex-to-segment lookup for the seven-segment scanner.
package seven_segment_pkg;

    typedef logic [6:0] segments_t;

    // Active-high a..g patterns, bit0 = a, bit6 = g
    localparam segments_t HexSegments [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic segments_t hex_to_segments(input logic [3:0] nibble);
        return HexSegments[nibble];
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational nibble to active-high segment pattern.
import seven_segment_pkg::*;

module seven_segment_decoder (
    input  logic [3:0] nibble_i,
    output segments_t  segments_o
);

    assign segments_o = hex_to_segments(nibble_i);

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment driver: double-buffered data, PWM duty,
// dead time between digits and leading-zero suppression.
import seven_segment_pkg::*;

module seven_segment_scanner #(
    parameter int NumDigits        = 4,
    parameter int RefreshPeriod    = 400_000,
    parameter int BlankCycles      = 16,
    parameter int BrightnessBits   = 4,
    parameter bit ActiveLowAnode   = 1'b1,
    parameter bit ActiveLowSegment = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NumDigits-1:0]    value,
    input  logic [NumDigits-1:0]      dots,
    input  logic [NumDigits-1:0]      digit_en,
    input  logic                      lz_blank,
    input  logic [BrightnessBits-1:0] brightness,
    input  logic                      load,
    output logic                      pending,
    output logic                      frame_start,
    output logic [NumDigits-1:0]      anode,
    output logic [6:0]                segments,
    output logic                      dot
);

    localparam int SlotTime = RefreshPeriod / NumDigits;
    localparam int SlotW    = (SlotTime > 1) ? $clog2(SlotTime) : 1;
    localparam int DigW     = (NumDigits > 1) ? $clog2(NumDigits) : 1;

    localparam logic [SlotW-1:0]     SlotLast = SlotW'(SlotTime - 1);
    localparam logic [DigW-1:0]      DigLast  = DigW'(NumDigits - 1);
    localparam logic [SlotW-1:0]     BlankCnt = SlotW'(BlankCycles);
    localparam logic [NumDigits-1:0] AnodeOff = {NumDigits{ActiveLowAnode}};
    localparam logic [6:0]           SegOff   = {7{ActiveLowSegment}};

    if (SlotTime <= BlankCycles + 2**BrightnessBits || NumDigits < 1) begin : g_param_check
        $error("seven_segment_scanner: slot too short or no digits");
    end

    logic [SlotW-1:0]          slot_cnt_q, slot_cnt_d;
    logic [DigW-1:0]           digit_idx_q, digit_idx_d;
    logic [BrightnessBits-1:0] bright_q;
    logic                      pending_q;

    logic [4*NumDigits-1:0] act_val_q, stg_val_q;
    logic [NumDigits-1:0]   act_dots_q, stg_dots_q;
    logic [NumDigits-1:0]   act_en_q, stg_en_q;
    logic                   act_lz_q, stg_lz_q;

    logic [NumDigits-1:0] anode_q;
    logic [6:0]           segments_q;
    logic                 dot_q;
    logic                 frame_start_q;

    logic boundary;
    assign boundary = (slot_cnt_q == '0) && (digit_idx_q == '0);

    always_comb begin
        slot_cnt_d  = slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_cnt_q == SlotLast) begin
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == DigLast) ? '0 : digit_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    // A load on the boundary cycle stages behind the data being applied
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= 1'b0;
            bright_q   <= '0;
            act_val_q  <= '0;
            act_dots_q <= '0;
            act_en_q   <= '0;
            act_lz_q   <= 1'b0;
            stg_val_q  <= '0;
            stg_dots_q <= '0;
            stg_en_q   <= '0;
            stg_lz_q   <= 1'b0;
        end else begin
            if (boundary && pending_q) begin
                act_val_q  <= stg_val_q;
                act_dots_q <= stg_dots_q;
                act_en_q   <= stg_en_q;
                act_lz_q   <= stg_lz_q;
            end
            if (load) begin
                stg_val_q  <= value;
                stg_dots_q <= dots;
                stg_en_q   <= digit_en;
                stg_lz_q   <= lz_blank;
            end
            pending_q <= load | (pending_q & ~boundary);
            if (slot_cnt_q == '0) begin
                bright_q <= brightness;
            end
        end
    end

    logic [3:0]                nibble;
    segments_t                 dec_seg;
    logic [NumDigits-1:0]      zero_from;
    logic                      zero_acc;
    logic                      cur_en, cur_dot, cur_zero;
    logic [NumDigits-1:0]      onehot;
    logic [SlotW-1:0]          phase;
    logic                      lit, suppress;
    logic [NumDigits-1:0]      anode_d;
    logic [6:0]                segments_d;
    logic                      dot_d;

    seven_segment_decoder u_decoder (
        .nibble_i   (nibble),
        .segments_o (dec_seg)
    );

    always_comb begin
        nibble    = '0;
        cur_en    = 1'b0;
        cur_dot   = 1'b0;
        cur_zero  = 1'b0;
        onehot    = '0;
        zero_from = '0;
        zero_acc  = 1'b1;
        for (int i = NumDigits - 1; i >= 0; i--) begin
            zero_acc     = zero_acc & (act_val_q[4*i +: 4] == 4'h0);
            zero_from[i] = zero_acc;
        end
        for (int i = 0; i < NumDigits; i++) begin
            if (digit_idx_q == DigW'(i)) begin
                nibble    = act_val_q[4*i +: 4];
                cur_en    = act_en_q[i];
                cur_dot   = act_dots_q[i];
                cur_zero  = zero_from[i];
                onehot[i] = 1'b1;
            end
        end
        phase    = slot_cnt_q - BlankCnt;
        lit      = (slot_cnt_q >= BlankCnt) && cur_en
                   && (phase[BrightnessBits-1:0] < bright_q);
        suppress = act_lz_q && (digit_idx_q != '0) && cur_zero;
        anode_d    = lit ? onehot : '0;
        segments_d = (lit && !suppress) ? dec_seg : 7'h00;
        dot_d      = lit && cur_dot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_q       <= AnodeOff;
            segments_q    <= SegOff;
            dot_q         <= ActiveLowSegment;
            frame_start_q <= 1'b0;
        end else begin
            anode_q       <= anode_d ^ AnodeOff;
            segments_q    <= segments_d ^ SegOff;
            dot_q         <= dot_d ^ ActiveLowSegment;
            frame_start_q <= boundary;
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_start_q;
    assign anode       = anode_q;
    assign segments    = segments_q;
    assign dot         = dot_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: vector table, corner sequences and
// random traffic, all checked each cycle against a time-based model.
module tb_seven_segment_scanner;

    localparam int ND    = 4;
    localparam int BC    = 4;
    localparam int BB    = 2;
    localparam int SLOT  = 100;
    localparam int FRAME = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dots, digit_en;
    logic        lz_blank;
    logic [1:0]  brightness;
    logic        load;
    logic        pending, frame_start;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        dot;

    seven_segment_scanner #(
        .NumDigits        (4),
        .RefreshPeriod    (400),
        .BlankCycles      (4),
        .BrightnessBits   (2),
        .ActiveLowAnode   (1'b1),
        .ActiveLowSegment (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .dots        (dots),
        .digit_en    (digit_en),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .load        (load),
        .pending     (pending),
        .frame_start (frame_start),
        .anode       (anode),
        .segments    (segments),
        .dot         (dot)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // model: n = cycles since reset release; data buffers
    int          n;
    int          o_c, o_d;
    logic [15:0] m_act_val, m_stg_val;
    logic [3:0]  m_act_dots, m_stg_dots, m_act_en, m_stg_en;
    logic        m_act_lz, m_stg_lz, m_pend;
    int          m_bright;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dot, e_fs, e_pend;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at t=%0t: got %0h expected %0h",
                         name, $time, act, exp);
        end
    endtask

    task automatic step();
        int c, d, nib;
        logic lit, sup;
        logic [3:0] sel;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dot = 1'b1;
            e_fs = 1'b0; e_pend = 1'b0; m_pend = 1'b0;
            m_act_val = '0; m_act_dots = '0; m_act_en = '0; m_act_lz = 1'b0;
            m_stg_val = '0; m_stg_dots = '0; m_stg_en = '0; m_stg_lz = 1'b0;
            m_bright = 0; n = 0; o_c = -1; o_d = -1;
        end else begin
            c   = n % SLOT;
            d   = (n / SLOT) % ND;
            nib = int'((m_act_val >> (4 * d)) & 16'hF);
            lit = (c >= BC) && m_act_en[d] && (((c - BC) % (1 << BB)) < m_bright);
            sup = m_act_lz && (d != 0) && ((m_act_val >> (4 * d)) == 16'h0);
            sel = 4'b0001 << d;
            e_an  = lit ? ~sel : 4'hF;
            e_seg = (lit && !sup) ? ~seg_lut[nib] : 7'h7F;
            e_dot = !(lit && m_act_dots[d]);
            e_fs  = (c == 0) && (d == 0);
            if (e_fs && m_pend) begin
                m_act_val = m_stg_val; m_act_dots = m_stg_dots;
                m_act_en = m_stg_en; m_act_lz = m_stg_lz;
                m_pend = 1'b0;
            end
            if (load) begin
                m_stg_val = value; m_stg_dots = dots;
                m_stg_en = digit_en; m_stg_lz = lz_blank;
                m_pend = 1'b1;
            end
            if (c == 0) m_bright = int'(brightness);
            e_pend = m_pend;
            o_c = c; o_d = d; n++;
        end
        @(posedge clk);
        #1;
        chk("anode", 32'(anode), 32'(e_an));
        chk("segments", 32'(segments), 32'(e_seg));
        chk("dot", 32'(dot), 32'(e_dot));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("pending", 32'(pending), 32'(e_pend));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dt,
                           input logic [3:0] en, input logic lz,
                           input logic [1:0] br);
        value = v; dots = dt; digit_en = en; lz_blank = lz;
        brightness = br; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_fs();
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            if (frame_start === 1'b1) found = 1;
        end
        if (!found) chk("wait_frame_start_timeout", 0, 1);
    endtask

    task automatic goto_slot(input int d, input int c);
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            if (o_d == d && o_c == c) found = 1;
        end
        if (!found) chk("goto_timeout", 0, 1);
    endtask

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dt;
        logic [3:0]  en;
        logic        lz;
        logic [1:0]  br;
        int          pd;
        int          pc;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dto;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cnt;
        rst = 1'b1; load = 1'b0; value = '0; dots = '0;
        digit_en = '0; lz_blank = 1'b0; brightness = '0;
        repeat (3) step();
        chk("reset_anode", 32'(anode), 32'hF);
        chk("reset_segments", 32'(segments), 32'h7F);
        rst = 1'b0;
        step();
        chk("first_frame_start", 32'(frame_start), 32'h1);

        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 0, 4, 4'hE, 7'h19, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 0, 7, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 3, 5, 4'h7, 7'h79, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 1, 2, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'h0050, 4'h8, 4'hF, 1'b1, 2'd3, 3, 4, 4'h7, 7'h7F, 1'b0});
        vecs.push_back('{16'h0050, 4'h8, 4'hF, 1'b1, 2'd3, 2, 4, 4'hB, 7'h7F, 1'b1});
        vecs.push_back('{16'h0050, 4'h8, 4'hF, 1'b1, 2'd3, 1, 4, 4'hD, 7'h12, 1'b1});
        vecs.push_back('{16'h0050, 4'h8, 4'hF, 1'b1, 2'd3, 0, 4, 4'hE, 7'h40, 1'b1});
        vecs.push_back('{16'h8888, 4'hF, 4'hB, 1'b0, 2'd3, 2, 4, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'h8888, 4'hF, 4'hB, 1'b0, 2'd3, 3, 6, 4'h7, 7'h00, 1'b0});
        vecs.push_back('{16'h00A0, 4'h0, 4'hF, 1'b0, 2'd1, 1, 4, 4'hD, 7'h08, 1'b1});
        vecs.push_back('{16'h00A0, 4'h0, 4'hF, 1'b0, 2'd1, 1, 5, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'hFEDC, 4'h0, 4'hF, 1'b0, 2'd1, 3, 8, 4'h7, 7'h0E, 1'b1});
        vecs.push_back('{16'hFEDC, 4'h0, 4'hF, 1'b0, 2'd1, 0, 4, 4'hE, 7'h46, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 4'hF, 1'b1, 2'd3, 0, 4, 4'hE, 7'h40, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 4'hF, 1'b1, 2'd3, 1, 4, 4'hD, 7'h7F, 1'b1});

        foreach (vecs[i]) begin
            if (n % FRAME == 0) step();
            do_load(vecs[i].v, vecs[i].dt, vecs[i].en, vecs[i].lz, vecs[i].br);
            wait_fs();
            goto_slot(vecs[i].pd, vecs[i].pc);
            chk($sformatf("vec%0d_anode", i), 32'(anode), 32'(vecs[i].an));
            chk($sformatf("vec%0d_seg", i), 32'(segments), 32'(vecs[i].seg));
            chk($sformatf("vec%0d_dot", i), 32'(dot), 32'(vecs[i].dto));
        end

        // brightness 0 then 1
        if (n % FRAME == 0) step();
        do_load(16'h1234, 4'h0, 4'hF, 1'b0, 2'd0);
        wait_fs();
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (anode !== 4'hF) cnt++;
        end
        chk("bright0_lit_cycles", 32'(cnt), 0);
        brightness = 2'd1;
        goto_slot(1, 0);
        cnt = 0;
        for (int i = 0; i < SLOT - 1; i++) begin
            step();
            if (anode === 4'hD) cnt++;
        end
        chk("bright1_lit_cycles", 32'(cnt), 24);

        // double buffering
        if (n % FRAME == 0) step();
        do_load(16'hAAAA, 4'h0, 4'hF, 1'b0, 2'd3);
        wait_fs();
        goto_slot(1, 50);
        do_load(16'hBBBB, 4'h0, 4'hF, 1'b0, 2'd3);
        chk("db_pending_set", 32'(pending), 1);
        goto_slot(3, 4);
        chk("db_old_shown", 32'(segments), 32'h08);
        wait_fs();
        step();
        chk("db_pending_clear", 32'(pending), 0);
        goto_slot(2, 4);
        chk("db_new_shown", 32'(segments), 32'h03);

        // load on the boundary cycle
        if (n % FRAME == 0) step();
        do_load(16'h1111, 4'h0, 4'hF, 1'b0, 2'd3);
        for (int i = 0; i < FRAME && n % FRAME != 0; i++) step();
        do_load(16'h2222, 4'h0, 4'hF, 1'b0, 2'd3);
        chk("coll_frame_start", 32'(frame_start), 1);
        chk("coll_pending_kept", 32'(pending), 1);
        goto_slot(0, 4);
        chk("coll_old_staging", 32'(segments), 32'h79);
        wait_fs();
        step();
        chk("coll_pending_clear", 32'(pending), 0);
        goto_slot(0, 4);
        chk("coll_new_value", 32'(segments), 32'h24);

        // reset while digit 2 is lit, with staged data outstanding
        if (n % FRAME == 0) step();
        do_load(16'h1234, 4'h1, 4'hF, 1'b0, 2'd3);
        wait_fs();
        goto_slot(2, 4);
        chk("rst_pre_anode", 32'(anode), 32'hB);
        do_load(16'h5555, 4'h0, 4'hF, 1'b0, 2'd3);
        rst = 1'b1;
        step();
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_segments", 32'(segments), 32'h7F);
        chk("rst_dot", 32'(dot), 1);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_release_fs", 32'(frame_start), 1);
        goto_slot(0, 4);
        chk("rst_digits_disabled", 32'(anode), 32'hF);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                value = 16'($urandom) & (($urandom_range(0, 1) == 0) ? 16'h00FF : 16'hFFFF);
                dots = 4'($urandom);
                digit_en = 4'($urandom) | 4'h5;
                lz_blank = 1'($urandom);
                brightness = 2'($urandom);
                load = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                brightness = 2'($urandom);
            end
            if ($urandom_range(0, 1499) == 0) rst = 1'b1;
            step();
            load = 1'b0;
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
